ff_plasticity_pipe: RTL and testbench

Multi-lane, runtime-configurable Forward-Forward weight-update engine. It applies w_ij += LR·(pos_flag − sigmoid(goodness − theta))·y_i·x_j to a weight memory that stores LANES weights per word, updating up to LANES weights per read/write pair. Learning rate, threshold, active neuron count and active input count are all runtime inputs. It drives port B of the layer weight BRAM while inference owns port A, and it reports a per-pass saturation count to the training controller.

---
 rtl/ff_plasticity_pipe_if.sv | 24 ++
 rtl/ff_plasticity_pipe.sv | 244 ++++++++++++++++++++++++
 tb/tb_ff_plasticity_pipe.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/ff_plasticity_pipe_if.sv
// Weight-memory port B bundle for the Forward-Forward update engine.
// master: engine drives addr/en/we/wmask/wdata; slave: memory returns rdata.
interface ff_plasticity_pipe_if #(
    parameter int ADDR_W     = 8,
    parameter int LANES      = 4,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_W-1:0]                 w_addr;
    logic                              w_en;
    logic                              w_we;
    logic [LANES-1:0]                  w_wmask;
    logic [LANES-1:0][DATA_WIDTH-1:0]  w_wdata;
    logic [LANES-1:0][DATA_WIDTH-1:0]  w_rdata;

    modport master (
        output w_addr, w_en, w_we, w_wmask, w_wdata,
        input  w_rdata
    );

    modport slave (
        input  w_addr, w_en, w_we, w_wmask, w_wdata,
        output w_rdata
    );
endinterface

// File: rtl/ff_plasticity_pipe.sv
// Multi-lane Forward-Forward weight-update engine (w += lr*(pos-sig)*y*x).
// Ports: clk/rst_n, start/abort, pass config, x/y vectors, busy/done/sat_count, bus (port B).
module ff_plasticity_pipe #(
    parameter int NUM_NEURONS = 256,
    parameter int INPUT_SIZE  = 784,
    parameter int DATA_WIDTH  = 32,
    parameter int FRAC_BITS   = 16,
    parameter int LANES       = 4,
    parameter int WPR         = (INPUT_SIZE + LANES - 1) / LANES,
    parameter int ADDR_W      = $clog2(NUM_NEURONS * WPR),
    parameter int NAW         = $clog2(NUM_NEURONS + 1),
    parameter int IAW         = $clog2(INPUT_SIZE + 1)
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   start,
    input  logic                                   abort,
    input  logic                                   is_positive,
    input  logic signed [DATA_WIDTH-1:0]           goodness_in,
    input  logic signed [DATA_WIDTH-1:0]           lr_in,
    input  logic signed [DATA_WIDTH-1:0]           theta_in,
    input  logic [NAW-1:0]                         active_neurons,
    input  logic [IAW-1:0]                         active_inputs,
    input  logic [INPUT_SIZE-1:0][DATA_WIDTH-1:0]  input_acts,
    input  logic [NUM_NEURONS-1:0][DATA_WIDTH-1:0] output_acts,
    output logic                                   busy,
    output logic                                   done,
    output logic [15:0]                            sat_count,
    ff_plasticity_pipe_if.master                   bus
);
    localparam int DW = DATA_WIDTH;
    localparam int FB = FRAC_BITS;
    localparam int NW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam int WW = (WPR > 1) ? $clog2(WPR) : 1;
    localparam int CW = (WPR * LANES > 1) ? $clog2(WPR * LANES) : 1;

    localparam logic signed [DW-1:0] ONE   = DW'(1) << FB;
    localparam logic signed [DW-1:0] HALF  = DW'(1) << (FB - 1);
    localparam logic signed [DW-1:0] FOUR  = DW'(4) << FB;
    localparam logic signed [DW-1:0] NFOUR = -FOUR;
    localparam logic signed [DW-1:0] MAXV  = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] MINV  = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE, PREP, SIG, SCALE, YF, RD, WR, DONE
    } state_t;

    state_t state, next;

    logic signed [DW-1:0] gd_r, th_r, lr_r;
    logic signed [DW-1:0] x_r, sig_r, scaled_r, yf_r;
    logic                 pos_r;
    logic [NAW-1:0]       an_r, an_c;
    logic [IAW-1:0]       ai_r, ai_c;
    logic [WW-1:0]        wl_r, word_r;
    logic [NW-1:0]        n_r;
    logic [15:0]          sat_r;

    logic                 last_word, last_n;
    logic [ADDR_W-1:0]    addr_c;
    logic [CW-1:0]        word_base;
    logic [LANES-1:0]     lane_in, lane_sat;
    logic [16:0]          sat_inc, sat_sum;
    logic signed [DW-1:0] pos_v, diff_v;

    logic [LANES-1:0][DW-1:0] lane_new;
    logic [WPR*LANES-1:0][DW-1:0] xpad;

    // Product floor-shifted back to Q format, clipped to the word range.
    function automatic logic signed [DW-1:0] q_mul(
        input logic signed [DW-1:0] a,
        input logic signed [DW-1:0] b
    );
        logic signed [2*DW-1:0] p;
        logic [DW:0]            hi;
        p  = (2*DW)'(a) * (2*DW)'(b);
        p  = p >>> FB;
        hi = p[2*DW-1:DW-1];
        if (&hi || ~|hi) q_mul = p[DW-1:0];
        else if (p[2*DW-1]) q_mul = MINV;
        else q_mul = MAXV;
    endfunction

    // Returns {saturated, value}.
    function automatic logic [DW:0] add_sat(
        input logic [DW-1:0] a,
        input logic [DW-1:0] b,
        input logic          sub
    );
        logic [DW:0] s;
        if (sub) s = {a[DW-1], a} - {b[DW-1], b};
        else     s = {a[DW-1], a} + {b[DW-1], b};
        if (s[DW] != s[DW-1]) add_sat = {1'b1, s[DW] ? MINV : MAXV};
        else                  add_sat = {1'b0, s[DW-1:0]};
    endfunction

    // Pad x to whole words so lanes past INPUT_SIZE read zero.
    assign xpad = (WPR*LANES*DW)'(input_acts);

    assign an_c = (32'(active_neurons) > NUM_NEURONS) ?
                  NAW'(NUM_NEURONS) : active_neurons;
    assign ai_c = (32'(active_inputs) > INPUT_SIZE) ?
                  IAW'(INPUT_SIZE) : active_inputs;

    assign last_word = (word_r == wl_r);
    assign last_n    = (32'(n_r) + 1 == 32'(an_r));
    assign addr_c    = ADDR_W'(32'(n_r) * WPR + 32'(word_r));
    assign word_base = CW'(word_r) * CW'(LANES);
    assign pos_v     = pos_r ? ONE : -ONE;
    assign diff_v    = pos_v - sig_r;
    assign sat_count = sat_r;

    always_comb begin
        lane_in  = '0;
        lane_sat = '0;
        lane_new = '0;
        sat_inc  = '0;
        for (int k = 0; k < LANES; k++) begin
            {lane_sat[k], lane_new[k]} = add_sat(
                bus.w_rdata[k],
                q_mul(yf_r, xpad[word_base + CW'(k)]),
                1'b0);
            lane_in[k] = (32'(word_base) + k) < 32'(ai_r);
            sat_inc = sat_inc + 17'(lane_in[k] & lane_sat[k]);
        end
    end

    assign sat_sum = {1'b0, sat_r} + sat_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next;
    end

    always_comb begin
        next        = state;
        busy        = 1'b0;
        done        = 1'b0;
        bus.w_en    = 1'b0;
        bus.w_we    = 1'b0;
        bus.w_addr  = '0;
        bus.w_wmask = '0;
        bus.w_wdata = '0;
        unique case (state)
            IDLE: if (start) next = PREP;
            PREP: begin
                busy = 1'b1;
                next = SIG;
            end
            SIG: begin
                busy = 1'b1;
                next = SCALE;
            end
            SCALE: begin
                busy = 1'b1;
                if (an_r == '0 || ai_r == '0) next = DONE;
                else next = YF;
            end
            YF: begin
                busy = 1'b1;
                next = RD;
            end
            RD: begin
                busy       = 1'b1;
                bus.w_en   = 1'b1;
                bus.w_addr = addr_c;
                next       = WR;
            end
            WR: begin
                busy        = 1'b1;
                bus.w_en    = 1'b1;
                bus.w_we    = 1'b1;
                bus.w_addr  = addr_c;
                bus.w_wmask = lane_in;
                bus.w_wdata = lane_new;
                if (!last_word)  next = RD;
                else if (!last_n) next = YF;
                else             next = DONE;
            end
            DONE: begin
                done = 1'b1;
                next = IDLE;
            end
            default: next = IDLE;
        endcase
        if (abort && state != IDLE) begin
            next     = IDLE;
            bus.w_we = 1'b0;
            done     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gd_r     <= '0;
            th_r     <= '0;
            lr_r     <= '0;
            pos_r    <= 1'b0;
            an_r     <= '0;
            ai_r     <= '0;
            wl_r     <= '0;
            x_r      <= '0;
            sig_r    <= '0;
            scaled_r <= '0;
            yf_r     <= '0;
            n_r      <= '0;
            word_r   <= '0;
            sat_r    <= '0;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    gd_r   <= goodness_in;
                    th_r   <= theta_in;
                    lr_r   <= lr_in;
                    pos_r  <= is_positive;
                    an_r   <= an_c;
                    ai_r   <= ai_c;
                    wl_r   <= WW'((32'(ai_c) + LANES - 1) / LANES - 1);
                    n_r    <= '0;
                    word_r <= '0;
                    sat_r  <= '0;
                end
                PREP:  x_r <= add_sat(gd_r, th_r, 1'b1);
                SIG: begin
                    if (x_r <= NFOUR)    sig_r <= '0;
                    else if (x_r >= FOUR) sig_r <= ONE;
                    else                 sig_r <= (x_r >>> 3) + HALF;
                end
                SCALE: scaled_r <= q_mul(lr_r, diff_v);
                YF:    yf_r <= q_mul(scaled_r, output_acts[n_r]);
                WR: if (!abort) begin
                    sat_r <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
                    if (!last_word) begin
                        word_r <= word_r + 1'b1;
                    end else begin
                        word_r <= '0;
                        n_r    <= n_r + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ff_plasticity_pipe.sv
// Directed scoreboard bench for ff_plasticity_pipe (4 neurons, 6 inputs, 4 lanes).
// Expected writes are queued per pass and checked as the DUT issues them.
module tb_ff_plasticity_pipe;
    localparam int NN = 4;
    localparam int IS = 6;
    localparam int DW = 32;
    localparam int LN = 4;
    localparam int AW = 3;

    typedef struct {
        logic [AW-1:0]        addr;
        logic [LN-1:0]        mask;
        logic [LN-1:0][31:0]  data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic is_positive = 1'b1;
    logic [31:0] goodness_in = '0;
    logic [31:0] lr_in = 32'h10000;
    logic [31:0] theta_in = '0;
    logic [2:0] active_neurons = '0;
    logic [2:0] active_inputs = '0;
    logic [IS-1:0][31:0] input_acts;
    logic [NN-1:0][31:0] output_acts;
    logic busy, done;
    logic [15:0] sat_count;

    logic [31:0] mem [8][LN];
    logic [LN-1:0][31:0] rdata = '0;
    exp_t sb[$];
    int errors = 0;
    int checks = 0;
    int en_seen = 0;
    int dc;

    ff_plasticity_pipe_if #(.ADDR_W(AW), .LANES(LN), .DATA_WIDTH(DW)) bus();

    assign bus.w_rdata = rdata;

    ff_plasticity_pipe #(
        .NUM_NEURONS(NN), .INPUT_SIZE(IS), .DATA_WIDTH(DW),
        .FRAC_BITS(16), .LANES(LN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .is_positive(is_positive), .goodness_in(goodness_in),
        .lr_in(lr_in), .theta_in(theta_in),
        .active_neurons(active_neurons), .active_inputs(active_inputs),
        .input_acts(input_acts), .output_acts(output_acts),
        .busy(busy), .done(done), .sat_count(sat_count), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b);
        logic [32:0] s;
        s = {a[31], a} + {b[31], b};
        if (s[32] != s[31]) return s[32] ? 32'h80000000 : 32'h7FFFFFFF;
        return s[31:0];
    endfunction

    // Memory model plus scoreboard check of every write.
    always @(posedge clk) begin
        exp_t e;
        if (bus.w_en) en_seen++;
        if (bus.w_en && bus.w_we) begin
            if (sb.size() == 0) begin
                chk("wr_unexpected", 32'(bus.w_addr), 32'hFFFFFFFF);
            end else begin
                e = sb.pop_front();
                chk("wr_addr", 32'(bus.w_addr), 32'(e.addr));
                chk("wr_mask", 32'(bus.w_wmask), 32'(e.mask));
                for (int k = 0; k < LN; k++)
                    if (e.mask[k]) chk("wr_data", bus.w_wdata[k], e.data[k]);
            end
            for (int k = 0; k < LN; k++)
                if (bus.w_wmask[k]) mem[bus.w_addr][k] = bus.w_wdata[k];
        end else if (bus.w_en) begin
            for (int k = 0; k < LN; k++) rdata[k] <= mem[bus.w_addr][k];
        end
    end

    task automatic preload(input logic [31:0] v);
        for (int a = 0; a < 8; a++)
            for (int k = 0; k < LN; k++) mem[a][k] = v;
    endtask

    task automatic push_pass(input int an, input int ai,
                             input logic [31:0] delta, input int max_wr);
        exp_t e;
        int cnt;
        cnt = 0;
        for (int n = 0; n < an; n++)
            for (int w = 0; w < (ai + LN - 1) / LN; w++) begin
                e.addr = AW'(n * 2 + w);
                for (int k = 0; k < LN; k++) begin
                    e.mask[k] = (w * LN + k) < ai;
                    e.data[k] = e.mask[k] ? sat_add(mem[e.addr][k], delta) : '0;
                end
                if (cnt < max_wr) sb.push_back(e);
                cnt++;
            end
    endtask

    task automatic run_pass(input logic pos, input logic [31:0] g,
                            input logic [2:0] an, input logic [2:0] ai,
                            input int pulse_at, input int abort_at,
                            output int done_cyc);
        @(negedge clk);
        is_positive = pos;
        goodness_in = g;
        theta_in = 32'h30000;
        active_neurons = an;
        active_inputs = ai;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        done_cyc = -1;
        for (int c = 1; c <= 60 && done_cyc < 0; c++) begin
            @(negedge clk);
            start = (c == pulse_at);
            if (c == abort_at) begin
                abort = 1'b1;
                #1 chk("abort_we", 32'(bus.w_we), 0);
            end
            if (abort_at > 0 && c == abort_at + 1) begin
                chk("abort_idle", 32'(busy), 0);
                abort = 1'b0;
            end
            if (done) done_cyc = c;
        end
        start = 1'b0;
        @(negedge clk);
        chk("done_pulse", 32'(done), 0);
        chk("busy_after", 32'(busy), 0);
        chk("sb_empty", 32'(sb.size()), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < IS; i++) input_acts[i] = 32'h10000;
        for (int i = 0; i < NN; i++) output_acts[i] = 32'h10000;
        preload('0);

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_sat", 32'(sat_count), 0);
        chk("rst_en", 32'(bus.w_en), 0);
        chk("rst_we", 32'(bus.w_we), 0);
        chk("rst_mask", 32'(bus.w_wmask), 0);
        chk("rst_addr", 32'(bus.w_addr), 0);
        chk("rst_wdata", 32'(bus.w_wdata != '0), 0);
        rst_n = 1'b1;

        // Positive pass, plus a stray start while busy
        preload('0);
        push_pass(4, 6, 32'h8000, 99);
        run_pass(1'b1, 32'h30000, 3'd4, 3'd6, 10, -1, dc);
        chk("s1_done_cyc", dc, 24);
        chk("s1_sat", 32'(sat_count), 0);
        chk("s1_w00", mem[0][0], 32'h8000);

        // Negative pass, sig = 1.0
        preload('0);
        push_pass(4, 6, 32'hFFFE0000, 99);
        run_pass(1'b0, 32'h80000, 3'd4, 3'd6, -1, -1, dc);
        chk("s2_done_cyc", dc, 24);
        chk("s2_w71", mem[7][1], 32'hFFFE0000);

        // Saturating pass
        preload(32'h7FFFFFF0);
        push_pass(4, 6, 32'h8000, 99);
        run_pass(1'b1, 32'h30000, 3'd4, 3'd6, -1, -1, dc);
        chk("s3_done_cyc", dc, 24);
        chk("s3_sat", 32'(sat_count), 24);
        repeat (3) @(negedge clk);
        chk("s3_sat_hold", 32'(sat_count), 24);

        // Zero active neurons
        en_seen = 0;
        run_pass(1'b1, 32'h30000, 3'd0, 3'd6, -1, -1, dc);
        chk("s5_done_cyc", dc, 4);
        chk("s5_no_en", en_seen, 0);
        chk("s5_sat_clr", 32'(sat_count), 0);

        // Abort in the third WR
        preload(32'h100);
        push_pass(4, 6, 32'h8000, 2);
        run_pass(1'b1, 32'h30000, 3'd4, 3'd6, -1, 11, dc);
        chk("s4_no_done", dc, 32'hFFFFFFFF);
        chk("s4_sat", 32'(sat_count), 0);
        chk("s4_w10", mem[1][0], 32'h8100);
        for (int a = 2; a < 8; a++)
            chk("s4_untouched", mem[a][0], 32'h100);

        // Five active inputs
        preload(32'h55);
        push_pass(4, 5, 32'h8000, 99);
        run_pass(1'b1, 32'h30000, 3'd4, 3'd5, -1, -1, dc);
        chk("s6_done_cyc", dc, 24);
        for (int n = 0; n < NN; n++) begin
            chk("s6_col4", mem[n*2+1][0], 32'h8055);
            chk("s6_col5", mem[n*2+1][1], 32'h55);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
